// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce_pkg
//  Description : Shared constants for the switch input conditioner:
//                FSM state encoding, default settle time and clock rate.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_debounce_pkg;

    // Debounce FSM state encoding (1-bit, two states)
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_SETTLE = 1'b1;

    // System tick rate the default settle time is derived from
    localparam int unsigned TICK_HZ = 10_000_000;

    // 10 ms of settle time at TICK_HZ
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = TICK_HZ / 100;

endpackage : switch_debounce_pkg
`default_nettype wire

// File: rtl/switch_debounce_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Per-bit multi-flop synchroniser with asynchronous reset to 0.
//                Generic, usable for any asynchronous level input.
//  Ports       : clk      in  1            clock
//                reset    in  1            asynchronous active-high reset
//                i_async  in  WIDTH        asynchronous input vector
//                o_sync   out WIDTH        synchronised output (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    localparam int c_CHAIN_W = WIDTH * SYNC_STAGES;

    // All stages packed into one shift register; stage 0 in the low bits
    logic [c_CHAIN_W-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[c_CHAIN_W-WIDTH-1:0], i_async};
        end
    end

    assign o_sync = r_chain[c_CHAIN_W-1 -: WIDTH];

endmodule : sync_chain
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : Synchronises and debounces the user switch vector as a whole.
//                A new value is committed only after the synchronised input
//                has held it for DEBOUNCE_CYCLES+1 consecutive samples.
//  Ports       : clk         in  1      single clock
//                reset       in  1      asynchronous active-high reset
//                sw_raw      in  WIDTH  raw asynchronous switch inputs
//                sw_stable   out WIDTH  debounced value (registered)
//                sw_changed  out 1      one-cycle strobe on each commit
//                sw_zero     out 1      registered, 1 when sw_stable == 0
//                sw_rise     out WIDTH  bits going 0->1 at commit (optional)
//                sw_fall     out WIDTH  bits going 1->0 at commit (optional)
//  Config      : define SWITCH_DEBOUNCE_EDGE_FLAGS_EN to add sw_rise/sw_fall.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int          WIDTH           = 8,
    parameter int          SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int          CNT_W           = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic             sw_zero
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
    ,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_sync;

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_stable;
    logic             r_changed;
    logic             r_zero;

    logic             w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_cand_nxt;
    logic             w_commit;

    sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (sw_raw),
        .o_sync  (w_sync)
    );

    // ------------------------------------------------------------------
    // FSM state, settle counter and candidate
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // The counter counts matching samples of the candidate, the entry
    // sample included, so commit happens on sample DEBOUNCE_CYCLES+1.
    // It never passes c_CNT_MAX because reaching it always commits.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sync != r_stable) begin
                    w_state_nxt = ST_SETTLE;
                    w_cand_nxt  = w_sync;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (w_sync == r_cand) begin
                    if (r_cnt >= c_CNT_MAX) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end else if (w_sync == r_stable) begin
                    // Input bounced back to the committed value
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    // Input moved to yet another value: restart settling
                    w_cand_nxt  = w_sync;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable  <= '0;
            r_changed <= 1'b0;
            r_zero    <= 1'b1;
        end else begin
            r_changed <= w_commit;
            if (w_commit) begin
                r_stable <= r_cand;
                r_zero   <= (r_cand == '0);
            end
        end
    end

    assign sw_stable  = r_stable;
    assign sw_changed = r_changed;
    assign sw_zero    = r_zero;

`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // Compared against the value being replaced, so flags match the strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rise <= '0;
            r_fall <= '0;
        end else if (w_commit) begin
            r_rise <= r_cand & ~r_stable;
            r_fall <= ~r_cand & r_stable;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
        end
    end

    assign sw_rise = r_rise;
    assign sw_fall = r_fall;
`endif

endmodule : switch_debounce
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debounce
//  Description : Self-checking bench for switch_debounce with
//                DEBOUNCE_CYCLES=4, SYNC_STAGES=2. A reference model tracks
//                the synchronised sample stream and commits a value once it
//                has been seen DEBOUNCE_CYCLES+1 times in a row.
//  Config      : honours SWITCH_DEBOUNCE_EDGE_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int c_W     = 8;
    localparam int c_SYNC  = 2;
    localparam int c_DEB   = 4;
    localparam int c_LAT   = c_SYNC + c_DEB + 1;

    logic           clk;
    logic           reset;
    logic [c_W-1:0] sw_raw;
    logic [c_W-1:0] sw_stable;
    logic           sw_changed;
    logic           sw_zero;
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
    logic [c_W-1:0] sw_rise;
    logic [c_W-1:0] sw_fall;
`endif

    switch_debounce #(
        .WIDTH           (c_W),
        .SYNC_STAGES     (c_SYNC),
        .DEBOUNCE_CYCLES (c_DEB),
        .CNT_W           (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_stable  (sw_stable),
        .sw_changed (sw_changed),
        .sw_zero    (sw_zero)
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
        ,
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int n_strobe;

    // Reference model state
    logic [c_W-1:0] m_pipe[$];
    logic [c_W-1:0] m_run_val;
    int             m_run_len;
    logic [c_W-1:0] m_stable;
    logic           m_changed;
    logic           m_zero;
    logic [c_W-1:0] m_rise;
    logic [c_W-1:0] m_fall;

    typedef struct {
        logic [c_W-1:0] raw;
        int             hold;
        logic [c_W-1:0] exp_stable;
        logic           exp_zero;
        int             exp_strobes;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < c_SYNC; i++) m_pipe.push_back('0);
        m_run_val = '0;
        m_run_len = 0;
        m_stable  = '0;
        m_changed = 1'b0;
        m_zero    = 1'b1;
        m_rise    = '0;
        m_fall    = '0;
    endtask

    // One clock edge of the reference: the synchroniser is a pure delay,
    // the debouncer commits on the (DEB+1)-th identical sample in a row.
    task automatic model_edge(input logic [c_W-1:0] raw);
        logic [c_W-1:0] s;
        s = m_pipe.pop_front();
        m_pipe.push_back(raw);
        if (s == m_run_val) begin
            if (m_run_len < 1000) m_run_len++;
        end else begin
            m_run_val = s;
            m_run_len = 1;
        end
        m_changed = 1'b0;
        m_rise    = '0;
        m_fall    = '0;
        if (s != m_stable && m_run_len == c_DEB + 1) begin
            m_rise    = s & ~m_stable;
            m_fall    = ~s & m_stable;
            m_stable  = s;
            m_changed = 1'b1;
            m_zero    = (s == '0);
        end
    endtask

    task automatic chk_outputs(input string nm);
        chk({nm, ".stable"},  32'(sw_stable),  32'(m_stable));
        chk({nm, ".changed"}, 32'(sw_changed), 32'(m_changed));
        chk({nm, ".zero"},    32'(sw_zero),    32'(m_zero));
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
        chk({nm, ".rise"},    32'(sw_rise),    32'(m_rise));
        chk({nm, ".fall"},    32'(sw_fall),    32'(m_fall));
`endif
    endtask

    // Drive sw_raw, take one edge, sample 1 time unit after it
    task automatic step(input logic [c_W-1:0] raw, input string nm);
        sw_raw = raw;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge(raw);
        #1;
        if (sw_changed === 1'b1) n_strobe++;
        chk_outputs(nm);
    endtask

    // Apply a new value and count edges up to the commit strobe
    task automatic latency_check(input logic [c_W-1:0] raw, input string nm);
        int k;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step(raw, nm);
            if (sw_changed === 1'b1 && k == 0) k = i;
        end
        if (k == 0) k = 99;
        chk({nm, ".latency"}, 32'(k), 32'(c_LAT));
        chk({nm, ".value"},   32'(sw_stable), 32'(raw));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   s0;
        int   s1;
        int   blen;
        logic [c_W-1:0] tgt;

        n_vec    = 0;
        n_err    = 0;
        n_strobe = 0;
        model_reset();

        tbl[0] = '{8'h00, 10, 8'h00, 1'b1, 1};
        tbl[1] = '{8'h05, 10, 8'h05, 1'b0, 1};
        tbl[2] = '{8'h00, 10, 8'h00, 1'b1, 1};
        tbl[3] = '{8'h05,  2, 8'h00, 1'b1, 0};
        tbl[4] = '{8'h00, 10, 8'h00, 1'b1, 0};
        tbl[5] = '{8'h05,  3, 8'h00, 1'b1, 0};
        tbl[6] = '{8'h0A, 10, 8'h0A, 1'b0, 1};
        tbl[7] = '{8'h00, 10, 8'h00, 1'b1, 1};
        tbl[8] = '{8'hFF,  4, 8'h00, 1'b1, 0};
        tbl[9] = '{8'h3C, 10, 8'h3C, 1'b0, 1};

        // Power-on reset
        reset  = 1'b1;
        sw_raw = '0;
        repeat (3) step(8'h00, "por");
        reset = 1'b0;
        repeat (4) step(8'h00, "idle");

        // Clean step 00 -> 05, exact latency, then no further strobes
        latency_check(8'h05, "step05");
        s0 = n_strobe;
        repeat (10) step(8'h05, "hold05");
        chk("hold05.strobes", 32'(n_strobe - s0), 32'd0);

        // Reset asserted mid-SETTLE while sw_raw = FF
        repeat (3) step(8'hFF, "preff");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_outputs("async_rst");
        repeat (2) step(8'hFF, "in_rst");
        reset = 1'b0;
        s0 = n_strobe;
        latency_check(8'hFF, "rel_ff");
        chk("rel_ff.strobes", 32'(n_strobe - s0), 32'd1);
        chk("rel_ff.zero", 32'(sw_zero), 32'd0);

        // Table-driven scenarios: clean steps, bounces, retarget, back to 0
        for (int r = 0; r < 10; r++) begin
            s0 = n_strobe;
            for (int h = 0; h < tbl[r].hold; h++) step(tbl[r].raw, $sformatf("row%0d", r));
            chk($sformatf("row%0d.stable", r),  32'(sw_stable), 32'(tbl[r].exp_stable));
            chk($sformatf("row%0d.zero", r),    32'(sw_zero),   32'(tbl[r].exp_zero));
            chk($sformatf("row%0d.strobes", r), 32'(n_strobe - s0), 32'(tbl[r].exp_strobes));
        end

        // Random glitch bursts shorter than DEB+1 samples, then a held target
        for (int it = 0; it < 40; it++) begin
            blen = int'($urandom_range(1, c_DEB));
            for (int b = 0; b < blen; b++) step(8'($urandom), "rnd_burst");
            tgt = (it % 5 == 0) ? 8'h00 : 8'($urandom);
            s1 = n_strobe;
            repeat (c_LAT + 2) step(tgt, "rnd_hold");
            chk("rnd.settled", 32'(sw_stable), 32'(tgt));
            if (n_strobe - s1 > 1) chk("rnd.strobes", 32'(n_strobe - s1), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_switch_debounce
`default_nettype wire
